// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the cache-port arbiter: FSM states,
// owner encodings and the default watchdog length.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin pick. Bit 0 is the fetcher, bit 1 the memory stage;
// on a tie the requester that did not win last time is chosen.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_grant,
  output logic       o_valid
);

  always_comb begin
    o_valid = |i_req;
    o_grant = OWNER_IF;
    if (&i_req) begin
      o_grant = ~i_last_grant;
    end else if (i_req[1]) begin
      o_grant = OWNER_DM;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one cache port between the instruction fetcher and the memory stage:
// round-robin grant, one-cycle strobe, wait for completion or watchdog, respond.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  input  logic                    if_ack,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_done,
  output logic                    if_err,
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_be,
  input  logic                    dm_ack,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    dm_done,
  output logic                    dm_err,
  output logic [ADDR_WIDTH-1:0]   port_addr,
  output logic [DATA_WIDTH-1:0]   port_wdata,
  output logic [DATA_WIDTH/8-1:0] port_byte_enable,
  output logic                    port_read_enable,
  output logic                    port_write_enable,
  input  logic [DATA_WIDTH-1:0]   port_rdata,
  input  logic                    port_data_valid,
  input  logic                    port_write_complete,
  output logic                    busy,
  output logic                    grant_owner
);

  localparam int unsigned          CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  logic                  r_last_grant;
  logic                  r_we;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_grant;
  logic                  w_valid;
  logic                  w_complete;
  logic                  w_timeout;
  logic                  w_ack;
  logic [DATA_WIDTH-1:0] w_rdata;

  rr_arbiter2 u_rr (
    .i_req        ({dm_req, if_req}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_valid      (w_valid)
  );

  // Completion beats expiry in the same cycle; a timeout always returns zero data.
  always_comb begin
    w_complete = r_we ? port_write_complete : port_data_valid;
    w_timeout  = (r_cnt == CNT_LAST);
    w_ack      = (grant_owner == OWNER_DM) ? dm_ack : if_ack;
    w_rdata    = (w_complete && !r_we) ? port_rdata : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state           <= IDLE;
      r_last_grant      <= OWNER_DM;
      r_we              <= 1'b0;
      r_cnt             <= '0;
      if_rdata          <= '0;
      if_done           <= 1'b0;
      if_err            <= 1'b0;
      dm_rdata          <= '0;
      dm_done           <= 1'b0;
      dm_err            <= 1'b0;
      port_addr         <= '0;
      port_wdata        <= '0;
      port_byte_enable  <= '0;
      port_read_enable  <= 1'b0;
      port_write_enable <= 1'b0;
      busy              <= 1'b0;
      grant_owner       <= OWNER_IF;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            grant_owner <= w_grant;
            busy        <= 1'b1;
            r_state     <= ISSUE;
            if (w_grant == OWNER_DM) begin
              port_addr         <= dm_addr;
              port_wdata        <= dm_wdata;
              port_byte_enable  <= dm_be;
              r_we              <= dm_we;
              port_write_enable <= dm_we;
              port_read_enable  <= ~dm_we;
            end else begin
              port_addr         <= if_addr;
              port_wdata        <= '0;
              port_byte_enable  <= '0;
              r_we              <= 1'b0;
              port_write_enable <= 1'b0;
              port_read_enable  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          port_read_enable  <= 1'b0;
          port_write_enable <= 1'b0;
          r_cnt             <= '0;
          r_state           <= WAIT;
        end
        WAIT: begin
          if (w_complete || w_timeout) begin
            r_state <= RESP;
            if (grant_owner == OWNER_DM) begin
              dm_done  <= 1'b1;
              dm_rdata <= w_rdata;
              dm_err   <= ~w_complete;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= w_rdata;
              if_err   <= ~w_complete;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          if (w_ack) begin
            if_done      <= 1'b0;
            if_rdata     <= '0;
            if_err       <= 1'b0;
            dm_done      <= 1'b0;
            dm_rdata     <= '0;
            dm_err       <= 1'b0;
            busy         <= 1'b0;
            r_last_grant <= grant_owner;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
